// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side bundle for both ports of ram_arbiter.
// master = requesters (load/store unit, debug/DMA); slave = the arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin sequencer for the single-port data RAM, IDLE->ISSUE->RESP.
// Optional per-port completion counters when RAM_ARB_STATS_EN is defined.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_store,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t                state;
  logic                  prio, owner, we;
  logic                  pick, any_req, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata, rdata_resp, rdata0_q, rdata1_q;
  always_comb begin
    any_req    = bus.req0 | bus.req1;
    pick       = (bus.req0 & bus.req1) ? prio : bus.req1;
    sel_we     = pick ? bus.we1 : bus.we0;
    sel_addr   = pick ? bus.addr1 : bus.addr0;
    sel_wdata  = pick ? bus.wdata1 : bus.wdata0;
    bus.gnt0   = (state == IDLE) & any_req & ~pick;
    bus.gnt1   = (state == IDLE) & any_req & pick;
    rdata_resp = we ? '0 : ram_data_out;
    // RAM read data only arrives in RESP, so the owner's rdata is passed through then
    bus.rdata0 = (state == RESP && !owner) ? rdata_resp : rdata0_q;
    bus.rdata1 = (state == RESP && owner) ? rdata_resp : rdata1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      we          <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      ram_store   <= 1'b0;
      ram_load    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      ram_store   <= 1'b0;
      ram_load    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          owner       <= pick;
          we          <= sel_we;
          ram_address <= sel_addr;
          ram_data_in <= sel_wdata;
          ram_store   <= sel_we;
          ram_load    <= ~sel_we;
          state       <= ISSUE;
        end
        ISSUE: begin
          bus.rvalid0 <= ~owner;
          bus.rvalid1 <= owner;
          state       <= RESP;
        end
        RESP: begin
          prio  <= ~owner;
          state <= IDLE;
          if (owner) rdata1_q <= rdata_resp;
          else rdata0_q <= rdata_resp;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (state == RESP) begin
      if (!owner && !(&cnt0)) cnt0 <= cnt0 + 1'b1;
      if (owner && !(&cnt1)) cnt1 <= cnt1 + 1'b1;
    end
  end
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed + random requests against a transaction-level model of the
// arbiter (grant slots every 3 cycles, round-robin tie rule, expected RAM contents).
module tb_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
`ifdef RAM_ARB_STATS_EN
  localparam int CW = 2;
  localparam bit STATS = 1'b1;
`else
  localparam int CW = 16;
  localparam bit STATS = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;
  logic          ram_store, ram_load;
  logic [CW-1:0] cnt0, cnt1;
  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_store(ram_store), .ram_load(ram_load), .ram_data_out(ram_data_out),
    .cnt0(cnt0), .cnt1(cnt1)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_store) ram[ram_address] <= ram_data_in;
    if (ram_load) ram_data_out <= ram[ram_address];
  end
  int compared = 0;
  int mismatched = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct packed {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } tx_t;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  tx_t           tx;
  longint        cyc = 0, g = -100, next_free = 0;
  bit            prio = 1'b0;
  bit            granted [2];
  logic [DW-1:0] last_rd [2];
  int            cnt [2];
  function automatic void model_reset();
    g = -100;
    next_free = cyc;
    prio = 1'b0;
    for (int p = 0; p < 2; p++) begin
      last_rd[p] = '0;
      cnt[p] = 0;
    end
  endfunction
  task automatic set_req(int p, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask
  task automatic cycle();
    bit r0, r1, w, issuing, resp;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    r0 = bus.req0;
    r1 = bus.req1;
    granted[0] = 1'b0;
    granted[1] = 1'b0;
    w = (r0 && r1) ? prio : r1;
    if (cyc >= next_free && (r0 || r1)) granted[w] = 1'b1;
    issuing = (cyc == g + 1);
    resp = (cyc == g + 2);
    check("gnt0", bus.gnt0, granted[0]);
    check("gnt1", bus.gnt1, granted[1]);
    check("ram_store", ram_store, issuing && tx.we);
    check("ram_load", ram_load, issuing && !tx.we);
    if (issuing) begin
      check("ram_address", ram_address, tx.addr);
      if (tx.we) check("ram_data_in", ram_data_in, tx.wdata);
    end
    check("rvalid0", bus.rvalid0, resp && !tx.owner);
    check("rvalid1", bus.rvalid1, resp && tx.owner);
    for (int p = 0; p < 2; p++) begin
      exp_rd = (resp && tx.owner == p[0]) ? (tx.we ? '0 : mem[tx.addr]) : last_rd[p];
      check(p == 0 ? "rdata0" : "rdata1", p == 0 ? bus.rdata0 : bus.rdata1, exp_rd);
      last_rd[p] = exp_rd;
      check(p == 0 ? "cnt0" : "cnt1", p == 0 ? cnt0 : cnt1, STATS ? cnt[p] : 0);
    end
    if (issuing && tx.we) mem[tx.addr] = tx.wdata;
    if (resp) begin
      prio = ~tx.owner;
      if (cnt[tx.owner] < (1 << CW) - 1) cnt[tx.owner]++;
    end
    if (granted[0] || granted[1]) begin
      tx = w ? {1'b1, bus.we1, bus.addr1, bus.wdata1} : {1'b0, bus.we0, bus.addr0, bus.wdata0};
      g = cyc;
      next_free = cyc + 3;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [AW-1:0] rnd_addr();
    case ($urandom_range(3))
      0: return '0;
      1: return '1;
      default: return AW'($urandom_range(15));
    endcase
  endfunction
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      mem[i] = '0;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_rvalid0", bus.rvalid0, 0);
    check("rst_rvalid1", bus.rvalid1, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_store", ram_store, 0);
    check("rst_load", ram_load, 0);
    check("rst_address", ram_address, 0);
    check("rst_data_in", ram_data_in, 0);
    check("rst_cnt1", cnt1, 0);
    rst_n = 1'b1;
    // single store then load back on port 0
    set_req(0, 1, 1, 12'd123, 32'h1234_cdef);
    cycle();
    set_req(0, 0, 0, '0, '0);
    repeat (3) cycle();
    set_req(0, 1, 0, 12'd123, '0);
    cycle();
    set_req(0, 0, 0, '0, '0);
    repeat (3) cycle();
    // tie of stores to both address extremes, then alternating loads
    set_req(0, 1, 1, 12'h000, 32'h5a5a_0001);
    set_req(1, 1, 1, 12'hfff, 32'ha5a5_0fff);
    repeat (6) cycle();
    set_req(0, 1, 0, 12'h000, '0);
    set_req(1, 1, 0, 12'hfff, '0);
    repeat (12) cycle();
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (3) cycle();
    // lone requester 1 back-to-back
    set_req(1, 1, 0, 12'hfff, '0);
    repeat (12) cycle();
    set_req(1, 0, 0, '0, '0);
    repeat (3) cycle();
    // reset during ISSUE of a store after port 0 was served last
    set_req(0, 1, 0, 12'd5, '0);
    cycle();
    set_req(0, 0, 0, '0, '0);
    repeat (3) cycle();
    set_req(1, 1, 1, 12'hfff, 32'hdead_beef);
    cycle();
    set_req(1, 0, 0, '0, '0);
    check("pre_rst_store", ram_store, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_store_drop", ram_store, 0);
    check("async_rvalid1", bus.rvalid1, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("held_rst_rvalid1", bus.rvalid1, 0);
    check("held_rst_load", ram_load, 0);
    rst_n = 1'b1;
    set_req(0, 1, 0, 12'hfff, '0);
    set_req(1, 1, 0, 12'h000, '0);
    repeat (6) cycle();
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (3) cycle();
    // random traffic; requests held until the model's grant, occasionally withdrawn
    repeat (400) begin
      for (int p = 0; p < 2; p++) begin
        bit r;
        r = (p == 0) ? bus.req0 : bus.req1;
        if (r && (granted[p] || $urandom_range(9) == 0)) begin
          set_req(p, 0, 0, '0, '0);
          r = 1'b0;
        end
        if (!r && $urandom_range(1) == 1)
          set_req(p, 1, 1'($urandom_range(1)), rnd_addr(), $urandom);
      end
      cycle();
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (4) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
